// File: rtl/m_result_drain.sv
// m_result_drain
//   Sits after the int-to-fp16 converter array. Takes one complete block of
//   ROWS x COLS fp16 results and their per-element converter status in a
//   single handshake. It then sends the block out one row per beat on a
//   valid/ready stream. Each beat carries an exception flag for its row.
//   A 16-bit counter records how many blocks have been fully drained.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   block present on in_fp / in_status
//   in_ready   block accepted when in_valid && in_ready (combinational)
//   in_fp      element [r][c] at ((r*COLS+c)*FP_W) +: FP_W
//   in_status  element [r][c] at ((r*COLS+c)*ST_W) +: ST_W
//   out_valid  row beat valid
//   out_ready  beat consumed when out_valid && out_ready
//   out_data   row payload, column c at c*FP_W +: FP_W
//   out_row    row index of the current beat
//   out_last   current beat is row ROWS-1
//   out_exc    OR over the row of status bits [1] inf, [2] invalid, [4] huge
//   blk_cnt    completed blocks, wraps 0xFFFF -> 0
module m_result_drain #(
  parameter  int ROWS = 7,
  parameter  int COLS = 8,
  parameter  int FP_W = 16,
  parameter  int ST_W = 8,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*COLS*FP_W-1:0] in_fp,
  input  logic [ROWS*COLS*ST_W-1:0] in_status,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*FP_W-1:0]      out_data,
  output logic [RW-1:0]             out_row,
  output logic                      out_last,
  output logic                      out_exc,
  output logic [15:0]               blk_cnt
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [15:0]            blk_cnt_q;
  logic [COLS*FP_W-1:0]   fp_rows [ROWS];
  logic [COLS*ST_W-1:0]   st_rows [ROWS];

  logic draining, is_last, capture, beat_hs, row_exc;

  assign draining = (state_q == DRAIN);
  assign is_last  = (row_q == RW'(ROWS - 1));
  assign beat_hs  = draining && out_ready;

  // A new block is accepted when idle, or on the cycle that retires the last
  // row, which lets consecutive blocks stream with no bubble.
  assign in_ready = !rst && (!draining || (is_last && out_ready));
  assign capture  = in_valid && in_ready;

  // Exception flag for the selected row: inf, invalid and huge only.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    row_exc = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      row_exc = row_exc | st_rows[row_q][c*ST_W + 1]
                        | st_rows[row_q][c*ST_W + 2]
                        | st_rows[row_q][c*ST_W + 4];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (capture) begin
      state_d = DRAIN;
      row_d   = '0;
    end else if (beat_hs) begin
      if (is_last) begin
        state_d = IDLE;
        row_d   = '0;
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (beat_hs && is_last) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  // NOTE: the block buffer has no reset; it is only observed while draining,
  // and outputs are forced to zero otherwise, so stale content never leaks.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < ROWS; r++) begin
        fp_rows[r] <= in_fp[r*COLS*FP_W +: COLS*FP_W];
        st_rows[r] <= in_status[r*COLS*ST_W +: COLS*ST_W];
      end
    end
  end

  assign out_valid = draining;
  assign out_data  = draining ? fp_rows[row_q] : '0;
  assign out_row   = row_q;
  assign out_last  = draining && is_last;
  assign out_exc   = draining && row_exc;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_m_result_drain.sv
module tb_m_result_drain;

  localparam int R  = 7;
  localparam int C  = 8;
  localparam int FW = 16;
  localparam int SW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [R*C*FW-1:0]  in_fp;
  logic [R*C*SW-1:0]  in_status;
  logic               out_valid, out_ready;
  logic [C*FW-1:0]    out_data;
  logic [2:0]         out_row;
  logic               out_last, out_exc;
  logic [15:0]        blk_cnt;

  // Second instance: single-row blocks, used for the counter wrap.
  logic               in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0]        in_fp1, out_data1;
  logic [15:0]        in_status1;
  logic [0:0]         out_row1;
  logic               out_last1, out_exc1;
  logic [15:0]        blk_cnt1;

  always #5 clk = ~clk;

  m_result_drain #(.ROWS(R), .COLS(C), .FP_W(FW), .ST_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fp(in_fp), .in_status(in_status), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .out_exc(out_exc), .blk_cnt(blk_cnt));

  m_result_drain #(.ROWS(1), .COLS(2), .FP_W(16), .ST_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_fp(in_fp1), .in_status(in_status1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_row(out_row1),
    .out_last(out_last1), .out_exc(out_exc1), .blk_cnt(blk_cnt1));

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- reference model: queue of expected row beats ----------
  typedef struct {
    logic [C*FW-1:0] data;
    int              row;
    bit              last;
    bit              exc;
  } beat_t;

  beat_t       q[$];
  logic [15:0] model_blk = 16'd0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          hs_cyc[$];
  int          rows_log[$];
  bit          last_log[$];
  logic [R-1:0] exc_seen;
  bit          exp_rdy;

  function automatic beat_t model_beat(input logic [R*C*FW-1:0] fp,
                                       input logic [R*C*SW-1:0] st, input int r);
    beat_t b;
    b.data = fp[r*C*FW +: C*FW];
    b.row  = r;
    b.last = (r == R - 1);
    b.exc  = 1'b0;
    for (int c = 0; c < C; c++) begin
      logic [SW-1:0] e;
      e = st[(r*C + c)*SW +: SW];
      b.exc = b.exc | e[1] | e[2] | e[4];
    end
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, q.size() != 0);
      check("blk_cnt", blk_cnt, model_blk);
      if (q.size() != 0) begin
        check("out_data", out_data, q[0].data);
        check("out_row", out_row, q[0].row);
        check("out_last", out_last, q[0].last);
        check("out_exc", out_exc, q[0].exc);
      end
      if (rst) begin
        q.delete();
        model_blk = 16'd0;
      end else begin
        if (q.size() != 0 && out_ready) begin
          hs_cyc.push_back(cyc);
          rows_log.push_back(int'(out_row));
          last_log.push_back(out_last);
          exc_seen[out_row] = out_exc;
          if (q[0].last) model_blk = model_blk + 16'd1;
          void'(q.pop_front());
        end
        if (in_valid && exp_rdy)
          for (int r = 0; r < R; r++) q.push_back(model_beat(in_fp, in_status, r));
      end
    end
  end

  // ---------------- out_ready driver -------------------------------------
  int       ready_mode = 0;   // 0 fixed, 1 pattern 1,0,0,1, 2 random
  bit       ready_fixed = 1'b1;
  bit [3:0] pat = 4'b1001;
  int       pidx = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
      2: begin out_ready = 1'($urandom_range(0, 1)); pidx = 0; end
      default: begin out_ready = ready_fixed; pidx = 0; end
    endcase
  end

  // ---------------- helpers ----------------------------------------------
  task automatic clear_logs();
    hs_cyc.delete();
    rows_log.delete();
    last_log.delete();
    exc_seen = '0;
  endtask

  task automatic send_block(input logic [R*C*FW-1:0] fp, input logic [R*C*SW-1:0] st);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_fp = fp; in_status = st; in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("send_block");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("wait_idle");
  endtask

  function automatic logic [R*C*FW-1:0] rand_fp();
    logic [R*C*FW-1:0] v;
    for (int i = 0; i < R*C; i++) v[i*FW +: FW] = 16'($urandom);
    return v;
  endfunction

  // ---------------- table of status vectors ------------------------------
  typedef struct {
    int          r;
    int          c;
    logic [7:0]  st;
    logic [R-1:0] exp_exc;
  } exc_vec_t;

  exc_vec_t vecs[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R*C*FW-1:0] fa, fb;
    logic [R*C*SW-1:0] st;
    int cnt;

    vecs[0] = '{r: 2, c: 5, st: 8'h10, exp_exc: 7'b0000100};
    vecs[1] = '{r: 4, c: 0, st: 8'h20, exp_exc: 7'b0000000};
    vecs[2] = '{r: 0, c: 0, st: 8'h02, exp_exc: 7'b0000001};
    vecs[3] = '{r: 6, c: 7, st: 8'h04, exp_exc: 7'b1000000};
    vecs[4] = '{r: 3, c: 3, st: 8'h01, exp_exc: 7'b0000000};
    vecs[5] = '{r: 1, c: 1, st: 8'h08, exp_exc: 7'b0000000};
    vecs[6] = '{r: 5, c: 2, st: 8'h16, exp_exc: 7'b0100000};

    rst = 1'b1; in_valid = 1'b0; in_fp = '0; in_status = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_fp1 = 32'hABCD1234; in_status1 = 16'h0010;

    // Reset state
    repeat (2) @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_blk_cnt", blk_cnt, 16'd0);
    check("rst_out_data", out_data, '0);
    check("rst_out_last", out_last, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // Single block, ramp payload, out_ready held high
    for (int i = 0; i < R*C; i++) fa[i*FW +: FW] = 16'(16'h3C00 + i);
    clear_logs();
    send_block(fa, '0);
    wait_idle();
    check("t1_beats", rows_log.size(), 7);
    for (int r = 0; r < R; r++) begin
      check("t1_row", rows_log[r], r);
      check("t1_last", last_log[r], (r == R - 1));
    end
    check("t1_consecutive", hs_cyc[6] - hs_cyc[0], 6);
    check("t1_blk_cnt", blk_cnt, 16'd1);
    check("t1_in_ready", in_ready, 1'b1);

    // Back-to-back blocks A,B
    for (int i = 0; i < R*C; i++) begin
      fa[i*FW +: FW] = 16'(16'h1000 + i);
      fb[i*FW +: FW] = 16'(16'h2000 + i);
    end
    clear_logs();
    send_block(fa, '0);
    send_block(fb, '0);
    wait_idle();
    check("t2_beats", rows_log.size(), 14);
    check("t2_no_gap", hs_cyc[13] - hs_cyc[0], 13);
    check("t2_a_row6", rows_log[6], 6);
    check("t2_b_row0", rows_log[7], 0);
    check("t2_blk_cnt", blk_cnt, 16'd3);

    // Backpressure 1,0,0,1
    ready_mode = 1;
    clear_logs();
    send_block(rand_fp(), '0);
    wait_idle();
    ready_mode = 0;
    check("t3_beats", rows_log.size(), 7);
    for (int r = 0; r < R; r++) check("t3_row", rows_log[r], r);
    check("t3_stalled", hs_cyc[6] - hs_cyc[0] > 6, 1'b1);
    check("t3_blk_cnt", blk_cnt, 16'd4);

    // Status table
    for (int v = 0; v < 7; v++) begin
      st = '0;
      st[(vecs[v].r*C + vecs[v].c)*SW +: SW] = vecs[v].st;
      clear_logs();
      send_block(rand_fp(), st);
      wait_idle();
      check("t4_exc_rows", exc_seen, vecs[v].exp_exc);
    end
    check("t4_blk_cnt", blk_cnt, 16'd11);

    // Reset at beat 3 of a drain
    send_block(rand_fp(), '1);
    cnt = 0;
    for (int t = 0; t < 50 && cnt < 3; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("t5_beat3", out_row, 3'd3);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_blk_cnt", blk_cnt, 16'd0);
    check("t5_out_data", out_data, '0);
    check("t5_out_exc", out_exc, 1'b0);
    clear_logs();
    send_block(rand_fp(), '0);
    wait_idle();
    check("t5_fresh_beats", rows_log.size(), 7);
    check("t5_fresh_row0", rows_log[0], 0);
    check("t5_blk_cnt_after", blk_cnt, 16'd1);

    // Randomized traffic against the model
    ready_mode = 2;
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < R*C; i++)
        st[i*SW +: SW] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      send_block(rand_fp(), st);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();
    ready_mode = 0;
    check("rnd_blk_cnt", blk_cnt, 16'd26);

    // Counter wrap on the single-row instance
    @(negedge clk);
    check("w_blk_cnt0", blk_cnt1, 16'd0);
    @(posedge clk); #1;
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    cnt = 0;
    for (int t = 0; t < 70000 && cnt < 65535; t++) begin
      @(negedge clk);
      if (out_valid1 && out_ready1) cnt++;
    end
    if (cnt < 65535) fail_now("wrap_count");
    @(negedge clk);
    check("w_blk_cnt_ffff", blk_cnt1, 16'hFFFF);
    check("w_last", out_last1, 1'b1);
    check("w_row", out_row1, 1'b0);
    check("w_data", out_data1, 32'hABCD1234);
    check("w_exc", out_exc1, 1'b1);
    check("w_in_ready", in_ready1, 1'b1);
    @(negedge clk);
    check("w_blk_cnt_wrap", blk_cnt1, 16'd0);
    @(posedge clk); #1;
    in_valid1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
